// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap/mret sequencer for the RV32 core.
// Zicsr accesses read the old value combinationally; traps and mret issue a registered fetch redirect.
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_req_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_no_write_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            irq_enable_o
);

  localparam logic [11:0] ADDR_MVENDORID  = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID    = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID     = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID    = 12'hF14;
  localparam logic [11:0] ADDR_MCONFIGPTR = 12'hF15;
  localparam logic [11:0] ADDR_MSTATUS    = 12'h300;
  localparam logic [11:0] ADDR_MISA       = 12'h301;
  localparam logic [11:0] ADDR_MTVEC      = 12'h305;
  localparam logic [11:0] ADDR_MEPC       = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE     = 12'h342;
  localparam logic [11:0] ADDR_MTVAL      = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] mcycle;

  logic            addr_hit;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] mstatus_val;
  logic            write_implied;
  logic            csr_we;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] mtvec_wval;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] vec_offset;

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[3]     = mie;
    mstatus_val[7]     = mpie;
    mstatus_val[12:11] = 2'b11;
  end

  always_comb begin
    addr_hit = 1'b1;
    old_val  = '0;
    case (csr_addr_i)
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MCONFIGPTR: old_val = '0;
      ADDR_MHARTID: old_val = HART_ID;
      ADDR_MSTATUS: old_val = mstatus_val;
      ADDR_MISA:    old_val = MISA_VALUE;
      ADDR_MTVEC:   old_val = mtvec;
      ADDR_MEPC:    old_val = mepc;
      ADDR_MCAUSE:  old_val = mcause;
      ADDR_MTVAL:   old_val = mtval;
      ADDR_MCYCLE:  old_val = mcycle;
      default:      addr_hit = 1'b0;
    endcase
  end

  assign csr_rdata_o   = old_val;
  assign write_implied = (csr_op_i == OP_RW) || !csr_no_write_i;
  assign csr_illegal_o = csr_req_i && (csr_op_i != OP_NONE) &&
                         (!addr_hit || ((csr_addr_i[11:10] == 2'b11) && write_implied));
  // Trap and mret outrank the CSR write, so a colliding write is simply dropped.
  assign csr_we = csr_req_i && (csr_op_i != OP_NONE) && !csr_illegal_o && write_implied &&
                  !trap_req_i && !mret_i;

  always_comb begin
    case (csr_op_i)
      OP_RW:   wval = csr_wdata_i;
      OP_RS:   wval = old_val | csr_wdata_i;
      default: wval = old_val & ~csr_wdata_i;
    endcase
  end

  // Reserved vector modes (2, 3) leave the current mode in place.
  assign mtvec_wval  = {wval[XLEN-1:2], wval[1] ? mtvec[1:0] : wval[1:0]};
  assign vec_offset  = ((mtvec[1:0] == 2'b01) && trap_cause_i[XLEN-1]) ?
                       ({1'b0, trap_cause_i[XLEN-2:0]} << 2) : '0;
  assign trap_target = {mtvec[XLEN-1:2], 2'b00} + vec_offset;

  assign irq_enable_o = mie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie              <= 1'b0;
      mpie             <= 1'b0;
      mtvec            <= RESET_MTVEC;
      mepc             <= '0;
      mcause           <= '0;
      mtval            <= '0;
      mcycle           <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= trap_req_i || mret_i;
      if (trap_req_i) begin
        redirect_pc_o <= trap_target;
        mepc          <= trap_pc_i & ~XLEN'(3);
        mcause        <= trap_cause_i;
        mtval         <= trap_tval_i;
        mpie          <= mie;
        mie           <= 1'b0;
      end else if (mret_i) begin
        redirect_pc_o <= mepc;
        mie           <= mpie;
        mpie          <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr_i)
          ADDR_MSTATUS: begin
            mie  <= wval[3];
            mpie <= wval[7];
          end
          ADDR_MTVEC:  mtvec  <= mtvec_wval;
          ADDR_MEPC:   mepc   <= wval & ~XLEN'(3);
          ADDR_MCAUSE: mcause <= wval;
          ADDR_MTVAL:  mtval  <= wval;
          default: ;
        endcase
      end
      if (csr_we && (csr_addr_i == ADDR_MCYCLE)) mcycle <= wval;
      else                                       mcycle <= mcycle + XLEN'(1);
    end
  end

endmodule
